// File: rtl/counter_checker.sv
`default_nettype none
// ============================================================================
// Module   : counter_checker
// Purpose  : Locks onto a free-running counter and flags deviations from +STEP.
// Revision : 1.0
// ============================================================================
module counter_checker #(
    parameter int unsigned      WIDTH      = 64,
    parameter logic [WIDTH-1:0] STEP       = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter int unsigned      LOCK_COUNT = 4,
    parameter int unsigned      ERR_CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_en,
    input  logic [WIDTH-1:0]     y,
    input  logic                 err_clr,
    output logic                 locked,
    output logic                 err_pulse,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [WIDTH-1:0]     expected
);

    localparam int unsigned RUN_W = $clog2(LOCK_COUNT + 1);
    localparam logic [RUN_W-1:0] c_lock_last = RUN_W'(LOCK_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [RUN_W-1:0]       r_run;
    logic [RUN_W-1:0]       w_run_nxt;
    logic [WIDTH-1:0]       w_expected_nxt;
    logic                   w_err;
    logic                   w_sticky_nxt;
    logic [ERR_CNT_W-1:0]   w_count_base;
    logic [ERR_CNT_W-1:0]   w_count_nxt;
    logic                   w_match;

    assign w_match = (y == expected);

    always_comb begin
        w_state_nxt    = r_state;
        w_run_nxt      = r_run;
        w_expected_nxt = expected;
        w_err          = 1'b0;
        if (sample_en) begin
            w_expected_nxt = y + STEP;
            case (r_state)
                ST_IDLE: begin
                    w_run_nxt   = '0;
                    w_state_nxt = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (w_match) begin
                        w_run_nxt = r_run + 1'b1;
                        if (r_run == c_lock_last)
                            w_state_nxt = ST_LOCKED;
                    end else begin
                        // Resynchronise silently; only a locked checker reports errors.
                        w_run_nxt = '0;
                    end
                end
                ST_LOCKED: begin
                    if (!w_match) begin
                        w_err       = 1'b1;
                        w_run_nxt   = '0;
                        w_state_nxt = ST_ACQUIRE;
                    end
                end
                default: begin
                    w_run_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // A clear and an error in the same cycle leave a count of one.
    always_comb begin
        w_count_base = err_clr ? '0 : err_count;
        w_count_nxt  = w_count_base;
        w_sticky_nxt = err_sticky & ~err_clr;
        if (w_err) begin
            w_sticky_nxt = 1'b1;
            if (!(&w_count_base))
                w_count_nxt = w_count_base + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_run      <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= '0;
            expected   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_run      <= w_run_nxt;
            locked     <= (w_state_nxt == ST_LOCKED);
            err_pulse  <= w_err;
            err_sticky <= w_sticky_nxt;
            err_count  <= w_count_nxt;
            expected   <= w_expected_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_counter_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_checker
// Purpose  : Directed scoreboard bench for counter_checker (main + 2-bit count).
// Revision : 1.0
// ============================================================================
module tb_counter_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_en = 1'b0;
    logic [63:0] y = '0;
    logic        err_clr = 1'b0;

    logic        locked, err_pulse, err_sticky;
    logic [15:0] err_count;
    logic [63:0] expected;
    logic        locked2, err_pulse2, err_sticky2;
    logic [1:0]  err_count2;
    logic [63:0] expected2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        bit          l, p, s;
        logic [15:0] c;
        logic [63:0] e;
    } exp_t;

    exp_t q[$];

    logic [63:0] cur;
    logic [15:0] cnt;

    always #5 clk = ~clk;

    counter_checker #(.WIDTH(64), .LOCK_COUNT(4), .ERR_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .sample_en(sample_en), .y(y), .err_clr(err_clr),
        .locked(locked), .err_pulse(err_pulse), .err_sticky(err_sticky),
        .err_count(err_count), .expected(expected)
    );

    counter_checker #(.WIDTH(64), .LOCK_COUNT(4), .ERR_CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .sample_en(sample_en), .y(y), .err_clr(err_clr),
        .locked(locked2), .err_pulse(err_pulse2), .err_sticky(err_sticky2),
        .err_count(err_count2), .expected(expected2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] sat2(input logic [15:0] c);
        return (c > 16'd3) ? 2'd3 : c[1:0];
    endfunction

    // Monitor: every pushed vector is compared just after the edge that consumes it.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                check({x.tag, ".locked"},     64'(locked),     64'(x.l));
                check({x.tag, ".err_pulse"},  64'(err_pulse),  64'(x.p));
                check({x.tag, ".err_sticky"}, 64'(err_sticky), 64'(x.s));
                check({x.tag, ".err_count"},  64'(err_count),  64'(x.c));
                check({x.tag, ".expected"},   expected,        x.e);
                check({x.tag, ".locked2"},    64'(locked2),    64'(x.l));
                check({x.tag, ".err_pulse2"}, 64'(err_pulse2), 64'(x.p));
                check({x.tag, ".err_count2"}, 64'(err_count2), 64'(sat2(x.c)));
                check({x.tag, ".expected2"},  expected2,       x.e);
            end
        end
    end

    task automatic step(input string tag, input bit en, input logic [63:0] yv, input bit clr,
                        input bit l, input bit p, input bit s,
                        input logic [15:0] c, input logic [63:0] e);
        exp_t x;
        @(negedge clk);
        sample_en = en;
        y         = yv;
        err_clr   = clr;
        x.tag = tag; x.l = l; x.p = p; x.s = s; x.c = c; x.e = e;
        q.push_back(x);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".locked"},     64'(locked),     64'd0);
        check({tag, ".err_pulse"},  64'(err_pulse),  64'd0);
        check({tag, ".err_sticky"}, 64'(err_sticky), 64'd0);
        check({tag, ".err_count"},  64'(err_count),  64'd0);
        check({tag, ".expected"},   expected,        64'd0);
        check({tag, ".err_count2"}, 64'(err_count2), 64'd0);
    endtask

    // Reset is asserted with sample_en high to show it overrides sampling.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst       = 1'b1;
        sample_en = 1'b1;
        err_clr   = 1'b0;
        #1;
        check_reset_state(tag);
        @(negedge clk);
        rst       = 1'b0;
        sample_en = 1'b0;
    endtask

    // Locked mismatch, then four matches to relock.
    task automatic force_error(input bit clr);
        logic [63:0] y0;
        y0  = cur + 64'd100;
        cnt = clr ? 16'd1 : cnt + 16'd1;
        step("err", 1'b1, y0, clr, 1'b0, 1'b1, 1'b1, cnt, y0 + 64'd1);
        for (int i = 1; i <= 4; i++)
            step("relock", 1'b1, y0 + 64'(i), 1'b0, (i == 4), 1'b0, 1'b1, cnt, y0 + 64'(i) + 64'd1);
        cur = y0 + 64'd5;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("por");
        @(negedge clk);
        rst = 1'b0;

        // Lock from IDLE on 0..4, run while locked, then one error and relock.
        step("lock0", 1, 64'd0, 0, 0, 0, 0, 16'd0, 64'd1);
        step("lock1", 1, 64'd1, 0, 0, 0, 0, 16'd0, 64'd2);
        step("lock2", 1, 64'd2, 0, 0, 0, 0, 16'd0, 64'd3);
        step("lock3", 1, 64'd3, 0, 0, 0, 0, 16'd0, 64'd4);
        step("lock4", 1, 64'd4, 0, 1, 0, 0, 16'd0, 64'd5);
        for (int i = 5; i <= 9; i++)
            step("run", 1, 64'(i), 0, 1, 0, 0, 16'd0, 64'(i + 1));
        step("err20", 1, 64'd20, 0, 0, 1, 1, 16'd1, 64'd21);
        step("re21",  1, 64'd21, 0, 0, 0, 1, 16'd1, 64'd22);
        step("re22",  1, 64'd22, 0, 0, 0, 1, 16'd1, 64'd23);
        step("re23",  1, 64'd23, 0, 0, 0, 1, 16'd1, 64'd24);
        step("re24",  1, 64'd24, 0, 1, 0, 1, 16'd1, 64'd25);
        step("hold0", 0, 64'd3,  0, 1, 0, 1, 16'd1, 64'd25);
        step("hold1", 0, 64'd3,  0, 1, 0, 1, 16'd1, 64'd25);
        step("clr",   0, 64'd3,  1, 1, 0, 0, 16'd0, 64'd25);
        cur = 64'd25;
        cnt = 16'd0;

        // Five errors (2-bit instance saturates), clear-with-error, then up to seven.
        for (int k = 0; k < 5; k++) force_error(1'b0);
        force_error(1'b1);
        for (int k = 0; k < 6; k++) force_error(1'b0);
        do_reset("rst_locked");

        // Wrap through all-ones.
        step("wrap0", 1, 64'hFFFF_FFFF_FFFF_FFFD, 0, 0, 0, 0, 16'd0, 64'hFFFF_FFFF_FFFF_FFFE);
        step("wrap1", 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 0, 16'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        step("wrap2", 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, 16'd0, 64'd0);
        step("wrap3", 1, 64'd0, 0, 0, 0, 0, 16'd0, 64'd1);
        step("wrap4", 1, 64'd1, 0, 1, 0, 0, 16'd0, 64'd2);
        do_reset("rst_wrap");

        // Mismatch during ACQUIRE only resynchronises.
        step("acq0", 1, 64'd0, 0, 0, 0, 0, 16'd0, 64'd1);
        step("acq1", 1, 64'd1, 0, 0, 0, 0, 16'd0, 64'd2);
        step("acq5", 1, 64'd5, 0, 0, 0, 0, 16'd0, 64'd6);
        step("acq6", 1, 64'd6, 0, 0, 0, 0, 16'd0, 64'd7);
        step("acq7", 1, 64'd7, 0, 0, 0, 0, 16'd0, 64'd8);
        step("acq8", 1, 64'd8, 0, 0, 0, 0, 16'd0, 64'd9);
        step("acq9", 1, 64'd9, 0, 1, 0, 0, 16'd0, 64'd10);
        do_reset("rst_acq");

        // Gapped sampling with junk on y during disabled cycles.
        for (int i = 0; i <= 4; i++) begin
            step("gap_s",  1, 64'(i),      0, (i == 4), 0, 0, 16'd0, 64'(i + 1));
            step("gap_h0", 0, 64'hDEAD,    0, (i == 4), 0, 0, 16'd0, 64'(i + 1));
            step("gap_h1", 0, 64'hBEEF,    0, (i == 4), 0, 0, 16'd0, 64'(i + 1));
        end
        step("gap_s5", 1, 64'd5, 0, 1, 0, 0, 16'd0, 64'd6);

        @(negedge clk);
        sample_en = 1'b0;
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
